sprite_ram_loader: RTL and testbench

SPRITE_RAM_LOADER -- requirements
Module: sprite_ram_loader

---
 rtl/sprite_ram_loader.sv | 115 +++++++++++
 tb/tb_sprite_ram_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_ram_loader.sv
// Sprite RAM loader: unpacks a byte stream (two pixels per byte) into a 2**ADDR_W x PIXEL_W
// dual-port RAM with a registered render-side read port. Define SPRITE_LOADER_CHECKSUM_EN to add a load checksum output.
module sprite_ram_loader #(
  parameter int PIXEL_W = 4,
  parameter int ADDR_W  = 10
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  output logic               busy,
  output logic               done,
  input  logic [ADDR_W-1:0]  address,
  output logic [PIXEL_W-1:0] q
`ifdef SPRITE_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]         checksum
`endif
);

  typedef enum logic [1:0] {IDLE, RECV, WR_HI, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   addr_hi;
  logic [3:0]          nib_q, nib_d;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [3:0]          wnib;
  logic [PIXEL_W-1:0]  q_q;

  logic [PIXEL_W-1:0]  mem [0:(1<<ADDR_W)-1];

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    nib_d     = nib_q;
    we        = 1'b0;
    waddr     = wr_addr_q;
    wnib      = byte_data[3:0];
    addr_hi   = wr_addr_q + ADDR_W'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          wr_addr_d = '0;
          state_d   = RECV;
        end
      end
      RECV: begin
        if (byte_valid) begin
          we      = 1'b1;
          nib_d   = byte_data[7:4];
          state_d = WR_HI;
        end
      end
      WR_HI: begin
        we        = 1'b1;
        waddr     = addr_hi;
        wnib      = nib_q;
        wr_addr_d = wr_addr_q + ADDR_W'(2);
        state_d   = (addr_hi == '1) ? DONE : RECV;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      nib_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      nib_q     <= nib_d;
    end
  end

  // Pixel storage is deliberately left out of reset so a partial load survives it.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= PIXEL_W'(wnib);
  end

  // Read-first: a same-cycle write is only visible on the following read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) q_q <= '0;
    else          q_q <= mem[address];
  end

  assign q          = q_q;
  assign byte_ready = (state_q == RECV);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (state_q == IDLE && start) cksum_d = '0;
    else if (we)                  cksum_d = cksum_q + {4'b0000, wnib};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cksum_q <= '0;
    else          cksum_q <= cksum_d;
  end

  assign checksum = cksum_q;
`endif

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed bench for sprite_ram_loader: read-back table, backpressure, ignored start,
// mid-load reset, read/write collision and (with SPRITE_LOADER_CHECKSUM_EN) checksum.
module tb_sprite_ram_loader;

  localparam int PIXEL_W = 4;
  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 1 << ADDR_W;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               start;
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  address;
  logic [PIXEL_W-1:0] q;
`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0]         checksum;
`endif

  sprite_ram_loader #(.PIXEL_W(PIXEL_W), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .busy       (busy),
    .done       (done),
    .address    (address),
    .q          (q)
`ifdef SPRITE_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_mem [DEPTH];
  int         bench_addr;
  int         exp_ck;
  int         tog_err, busy_err, early_done, tmo;

  typedef struct {
    int         addr;
    logic [3:0] exp;
  } rd_vec_t;
  rd_vec_t rd_tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input int kind, input int i);
    logic [3:0] lo, hi;
    lo = 4'((2 * i) % 16);
    hi = 4'((2 * i + 1) % 16);
    case (kind)
      0:       byte_of = {hi, lo};
      1:       byte_of = 8'hAB;
      2:       byte_of = 8'h00;
      3:       byte_of = 8'hFF;
      4:       byte_of = 8'h01;
      5:       byte_of = 8'(i * 7 + 3);
      6:       byte_of = 8'(i) ^ 8'hC3;
      default: byte_of = 8'h77;
    endcase
  endfunction

  task automatic begin_load();
    start = 1'b1;
    tick();
    start      = 1'b0;
    bench_addr = 0;
    exp_ck     = 0;
    tog_err    = 0;
    busy_err   = 0;
    early_done = 0;
    tmo        = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input int exp_n);
    int n;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_data  = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 8) begin
      if (done) early_done++;
      if (!busy) busy_err++;
      tick();
      n++;
    end
    if (!byte_ready) begin
      tmo++;
      byte_valid = 1'b0;
      return;
    end
    if (n != exp_n) tog_err++;
    tick();
    byte_valid = 1'b0;
    if (byte_ready) tog_err++;
    if (!busy) busy_err++;
    exp_mem[bench_addr]     = b[3:0];
    exp_mem[bench_addr + 1] = b[7:4];
    exp_ck     = (exp_ck + int'(b[3:0]) + int'(b[7:4])) % 256;
    bench_addr += 2;
  endtask

  task automatic finish_load(input string tag);
    chk({tag, "_timeout"}, tmo, 0);
    chk({tag, "_ready_toggle"}, tog_err, 0);
    chk({tag, "_busy_hold"}, busy_err, 0);
    chk({tag, "_early_done"}, early_done, 0);
    tick();
    chk({tag, "_done_pulse"}, done, 1);
    chk({tag, "_busy_in_done"}, busy, 1);
    tick();
    chk({tag, "_done_clear"}, done, 0);
    chk({tag, "_busy_clear"}, busy, 0);
`ifdef SPRITE_LOADER_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, exp_ck);
`endif
  endtask

  task automatic load(input int kind, input int gap, input int inject, input string tag);
    begin_load();
    for (int i = 0; i < DEPTH / 2; i++) begin
      if (i == inject) begin
        byte_valid = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      send_byte(byte_of(kind, i), gap, (gap == 0 && i > 0 && i != inject) ? 1 : 0);
      if (tmo != 0) break;
    end
    finish_load(tag);
  endtask

  task automatic verify(input string name);
    int mism = 0;
    for (int a = 0; a < DEPTH; a++) begin
      address = ADDR_W'(a);
      tick();
      if (q !== PIXEL_W'(exp_mem[a])) mism++;
    end
    chk(name, mism, 0);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #2;
    chk({tag, "_ready"}, byte_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_q"}, q, 0);
`ifdef SPRITE_LOADER_CHECKSUM_EN
    chk({tag, "_checksum"}, checksum, 0);
`endif
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // Ramp image: pixel p holds p mod 16.
    rd_tbl[0] = '{0, 4'h0};
    rd_tbl[1] = '{1, 4'h1};
    rd_tbl[2] = '{2, 4'h2};
    rd_tbl[3] = '{3, 4'h3};
    rd_tbl[4] = '{15, 4'hF};
    rd_tbl[5] = '{16, 4'h0};
    rd_tbl[6] = '{500, 4'h4};
    rd_tbl[7] = '{1022, 4'hE};
    rd_tbl[8] = '{1023, 4'hF};

    reset_n    = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    address    = '0;
    #3;
    chk("rst_ready", byte_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", q, 0);
`ifdef SPRITE_LOADER_CHECKSUM_EN
    chk("rst_checksum", checksum, 0);
`endif
    tick();
    reset_n = 1'b1;
    tick();

    load(0, 0, -1, "ramp");
    for (int k = 0; k < 9; k++) begin
      address = ADDR_W'(rd_tbl[k].addr);
      tick();
      chk($sformatf("ramp_rd_%0d", rd_tbl[k].addr), q, rd_tbl[k].exp);
    end

    load(5, 5, -1, "gap5");
    verify("gap5_image");

    load(6, 0, 50, "start_ignored");
    verify("start_ignored_image");

    // Reset with 10 bytes of 0xAB written; pixels 0..19 must survive.
    begin_load();
    for (int i = 0; i < 10; i++) send_byte(8'hAB, 0, (i > 0) ? 1 : 0);
    chk("partial_timeout", tmo, 0);
    address = ADDR_W'(1);
    tick();
    chk("partial_q_before_reset", q, 4'hA);
`ifdef SPRITE_LOADER_CHECKSUM_EN
    chk("partial_checksum", checksum, 8'hD2);
`endif
    do_reset("midload_rst");
    address = ADDR_W'(0);
    tick();
    chk("kept_pix0", q, 4'hB);
    verify("after_reset_image");

    load(2, 0, -1, "zeros");
    verify("zeros_image");

    // Collision: read pixel 6 while byte 3 (0x77) writes pixels 6/7.
    begin_load();
    for (int i = 0; i < 3; i++) send_byte(8'h77, 0, (i > 0) ? 1 : 0);
    address = ADDR_W'(6);
    send_byte(8'h77, 0, 1);
    chk("collide_old", q, 4'h0);
    tick();
    chk("collide_new", q, 4'h7);
    tick();
    chk("collide_new_hold", q, 4'h7);
    for (int i = 4; i < DEPTH / 2; i++) begin
      send_byte(8'h77, 0, (i > 4) ? 1 : 0);
      if (tmo != 0) break;
    end
    finish_load("collide");
    verify("collide_image");

`ifdef SPRITE_LOADER_CHECKSUM_EN
    load(3, 0, -1, "ff_load");
    chk("ff_checksum", checksum, 8'h00);
    load(5, 0, -1, "ck_nonzero");
    load(4, 0, -1, "01_load");
    chk("01_checksum", checksum, 8'h00);
    begin_load();
    send_byte(8'h21, 0, 0);
    tick();
    chk("x21_checksum", checksum, 8'h03);
    do_reset("x21_rst");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
